// File: rtl/sti_rx_deser.sv
// STI serial receiver: turns so_valid bursts into parallel words, checks the frame
// length and queues good words in a small FIFO with a valid/ready consumer interface.
module sti_rx_deser #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             so_data,
  input  logic             so_valid,
  input  logic [1:0]       cfg_length,
  input  logic             cfg_msb,
  output logic [31:0]      rx_data,
  output logic [1:0]       rx_len,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             frame_err,
  output logic [CNT_W-1:0] err_cnt,
  output logic             ovf
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OccW = $clog2(DEPTH + 1);

  // Bit counter saturates here so an over-long burst can never alias a valid length.
  localparam logic [5:0] CntSat = 6'd33;

  typedef enum logic [0:0] {StIdle, StRecv} state_e;

  // Receiver state
  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] acc_q, acc_d;
  logic [1:0]  len_q, len_d;
  logic        msb_q, msb_d;

  // Frame check
  logic        frame_end;
  logic [5:0]  exp_cnt;
  logic        frame_good;
  logic        frame_bad;
  logic [31:0] word_mask;
  logic [31:0] push_word;

  // FIFO
  logic [33:0]     mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [OccW-1:0] occ_q, occ_d;
  logic            fifo_full, fifo_empty;
  logic            pop, push_ok, drop;

  // Status
  logic             frame_err_q;
  logic [CNT_W-1:0] err_cnt_q;
  logic             ovf_q;

  // Receiver next-state: collect bits while so_valid is high, close the frame on the first low.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    len_d     = len_q;
    msb_d     = msb_q;
    frame_end = 1'b0;
    case (state_q)
      StIdle: begin
        if (so_valid) begin
          state_d = StRecv;
          len_d   = cfg_length;
          msb_d   = cfg_msb;
          cnt_d   = 6'd1;
          // First bit lands at bit 0 in both orders.
          acc_d   = {31'd0, so_data};
        end
      end
      StRecv: begin
        if (so_valid) begin
          if (cnt_q != CntSat) begin
            cnt_d = cnt_q + 6'd1;
          end
          if (msb_q) begin
            acc_d = {acc_q[30:0], so_data};
          end else if (cnt_q < 6'd32) begin
            acc_d[cnt_q[4:0]] = so_data;
          end
        end else begin
          state_d   = StIdle;
          frame_end = 1'b1;
          cnt_d     = 6'd0;
          acc_d     = 32'd0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Receiver state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= 6'd0;
      acc_q   <= 32'd0;
      len_q   <= 2'd0;
      msb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      len_q   <= len_d;
      msb_q   <= msb_d;
    end
  end

  // Length check and right-alignment of the assembled word.
  always_comb begin
    exp_cnt = {1'b0, len_q, 3'b000} + 6'd8;
    case (len_q)
      2'd0:    word_mask = 32'h0000_00FF;
      2'd1:    word_mask = 32'h0000_FFFF;
      2'd2:    word_mask = 32'h00FF_FFFF;
      default: word_mask = 32'hFFFF_FFFF;
    endcase
    frame_good = frame_end && (cnt_q == exp_cnt);
    frame_bad  = frame_end && (cnt_q != exp_cnt);
    push_word  = acc_q & word_mask;
  end

  // FIFO control: a pop in the same edge frees the slot for a push into a full FIFO.
  always_comb begin
    fifo_full  = (occ_q == OccW'(DEPTH));
    fifo_empty = (occ_q == '0);
    pop        = !fifo_empty && rx_ready;
    push_ok    = frame_good && (!fifo_full || pop);
    drop       = frame_good && fifo_full && !pop;
    occ_d      = occ_q;
    if (push_ok && !pop) begin
      occ_d = occ_q + OccW'(1);
    end else if (pop && !push_ok) begin
      occ_d = occ_q - OccW'(1);
    end
  end

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= {len_q, push_word};
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      occ_q <= occ_d;
    end
  end

  // Error pulse, saturating error counter and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      frame_err_q <= 1'b0;
      err_cnt_q   <= '0;
      ovf_q       <= 1'b0;
    end else begin
      frame_err_q <= frame_bad;
      if (frame_bad && (err_cnt_q != {CNT_W{1'b1}})) begin
        err_cnt_q <= err_cnt_q + CNT_W'(1);
      end
      if (drop) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // Head-of-FIFO view; zero while empty.
  always_comb begin
    rx_valid  = !fifo_empty;
    rx_data   = fifo_empty ? 32'd0 : mem_q[rd_ptr_q][31:0];
    rx_len    = fifo_empty ? 2'd0 : mem_q[rd_ptr_q][33:32];
    frame_err = frame_err_q;
    err_cnt   = err_cnt_q;
    ovf       = ovf_q;
  end

endmodule

// File: tb/tb_sti_rx_deser.sv
// Bench for sti_rx_deser: directed cases plus random frames checked every cycle
// against a frame-level reference model.
module tb_sti_rx_deser;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             so_data;
  logic             so_valid;
  logic [1:0]       cfg_length;
  logic             cfg_msb;
  logic [31:0]      rx_data;
  logic [1:0]       rx_len;
  logic             rx_valid;
  logic             rx_ready;
  logic             frame_err;
  logic [CNT_W-1:0] err_cnt;
  logic             ovf;

  always #5 clk = ~clk;

  sti_rx_deser #(
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .so_data   (so_data),
    .so_valid  (so_valid),
    .cfg_length(cfg_length),
    .cfg_msb   (cfg_msb),
    .rx_data   (rx_data),
    .rx_len    (rx_len),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .err_cnt   (err_cnt),
    .ovf       (ovf)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: frame = list of bits, FIFO = queue of {len, word}.
  logic [33:0] m_q[$];
  bit          m_bits[$];
  bit          m_in = 0;
  logic [1:0]  m_len = 0;
  bit          m_msb = 0;
  bit          m_ovf = 0;
  bit          m_ferr = 0;
  int          m_err = 0;

  function automatic logic [31:0] pack(input bit b[$], input bit msb, input logic [1:0] len);
    int          nb;
    logic [31:0] w;
    logic [31:0] mask;
    nb   = 8 * (int'(len) + 1);
    mask = (nb == 32) ? 32'hFFFF_FFFF : ((32'd1 << nb) - 32'd1);
    w    = 32'd0;
    for (int i = 0; i < b.size(); i++) begin
      if (msb) w = w * 2 + 32'(b[i]);
      else if (i < 32) w = w + (32'(b[i]) << i);
    end
    return w & mask;
  endfunction

  initial begin : model
    bit          pop;
    bit          push;
    logic [33:0] e;
    forever begin
      @(posedge clk);
      m_ferr = 0;
      if (!reset) begin
        m_q.delete();
        m_bits.delete();
        m_in  = 0;
        m_ovf = 0;
        m_err = 0;
      end else begin
        pop  = (m_q.size() > 0) && rx_ready;
        push = 0;
        e    = '0;
        if (m_in) begin
          if (so_valid) begin
            m_bits.push_back(so_data);
          end else begin
            m_in = 0;
            if (m_bits.size() == 8 * (int'(m_len) + 1)) begin
              if (m_q.size() < DEPTH || pop) begin
                push = 1;
                e    = {m_len, pack(m_bits, m_msb, m_len)};
              end else begin
                m_ovf = 1;
              end
            end else begin
              m_ferr = 1;
              if (m_err < (2 ** CNT_W) - 1) m_err++;
            end
          end
        end else if (so_valid) begin
          m_in  = 1;
          m_len = cfg_length;
          m_msb = cfg_msb;
          m_bits.delete();
          m_bits.push_back(so_data);
        end
        if (pop) void'(m_q.pop_front());
        if (push) m_q.push_back(e);
      end
    end
  end

  bit rnd_ready = 0;

  // Advance one cycle, then compare every output against the model.
  task automatic tick();
    logic [33:0] h;
    @(posedge clk);
    #1;
    h = (m_q.size() > 0) ? m_q[0] : 34'd0;
    check_val("rx_valid", 64'(rx_valid), 64'(m_q.size() > 0));
    check_val("rx_data", 64'(rx_data), 64'(h[31:0]));
    check_val("rx_len", 64'(rx_len), 64'(h[33:32]));
    check_val("frame_err", 64'(frame_err), 64'(m_ferr));
    check_val("err_cnt", 64'(err_cnt), 64'(m_err));
    check_val("ovf", 64'(ovf), 64'(m_ovf));
  endtask

  // Bit i of bits is sent in cycle i; then gap low cycles.
  task automatic send_frame(input int n, input logic [63:0] bits, input int gap,
                            input bit chg_len);
    for (int i = 0; i < n; i++) begin
      so_valid = 1'b1;
      so_data  = bits[i];
      if (chg_len && i == 1) cfg_length = 2'd0;
      if (rnd_ready) rx_ready = 1'($urandom);
      tick();
    end
    for (int g = 0; g < gap; g++) begin
      so_valid = 1'b0;
      so_data  = 1'($urandom);
      if (rnd_ready) rx_ready = 1'($urandom);
      tick();
    end
  endtask

  function automatic logic [63:0] msb_bits(input logic [31:0] w, input int n);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[i] = w[n-1-i];
    return r;
  endfunction

  task automatic do_reset();
    reset    = 1'b0;
    so_valid = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  initial begin : stim
    int          len;
    int          n;
    logic [63:0] bits;
    reset      = 1'b0;
    so_data    = 1'b0;
    so_valid   = 1'b0;
    cfg_length = 2'd0;
    cfg_msb    = 1'b1;
    rx_ready   = 1'b1;
    tick();
    tick();
    check_val("reset_rx_valid", 64'(rx_valid), 64'd0);
    check_val("reset_rx_data", 64'(rx_data), 64'd0);
    check_val("reset_err_cnt", 64'(err_cnt), 64'd0);
    reset = 1'b1;
    tick();

    // 8-bit MSB-first
    cfg_length = 2'd0;
    cfg_msb    = 1'b1;
    send_frame(8, 64'h83, 1, 0);
    check_val("msb8_valid", 64'(rx_valid), 64'd1);
    check_val("msb8_data", 64'(rx_data), 64'h0000_00C1);
    check_val("msb8_len", 64'(rx_len), 64'd0);
    tick();
    check_val("msb8_popped", 64'(rx_valid), 64'd0);

    // 8-bit LSB-first
    cfg_msb = 1'b0;
    send_frame(8, 64'h83, 1, 0);
    check_val("lsb8_data", 64'(rx_data), 64'h0000_0083);
    tick();

    // 32-bit MSB-first with a mid-frame length change
    cfg_length = 2'd3;
    cfg_msb    = 1'b1;
    send_frame(32, msb_bits(32'hDEAD_BEEF, 32), 1, 1);
    check_val("msb32_data", 64'(rx_data), 64'hDEAD_BEEF);
    check_val("msb32_len", 64'(rx_len), 64'd3);
    tick();

    // Bad lengths
    cfg_length = 2'd1;
    send_frame(12, 64'h0ABC, 1, 0);
    check_val("bad12_err", 64'(frame_err), 64'd1);
    check_val("bad12_cnt", 64'(err_cnt), 64'd1);
    check_val("bad12_valid", 64'(rx_valid), 64'd0);
    tick();
    check_val("bad12_pulse_end", 64'(frame_err), 64'd0);
    send_frame(17, 64'h1_2345, 1, 0);
    check_val("bad17_cnt", 64'(err_cnt), 64'd2);

    // Back-pressure: six frames into a 4-deep FIFO
    cfg_length = 2'd0;
    rx_ready   = 1'b0;
    for (int k = 1; k <= 6; k++) send_frame(8, msb_bits(32'(k), 8), 1, 0);
    check_val("bp_ovf", 64'(ovf), 64'd1);
    rx_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      check_val("bp_order", 64'(rx_data), 64'(k));
      tick();
    end
    check_val("bp_drained", 64'(rx_valid), 64'd0);

    // Full FIFO: frame end coincides with a pop
    do_reset();
    rx_ready = 1'b0;
    for (int k = 'h11; k <= 'h14; k++) send_frame(8, msb_bits(32'(k), 8), 1, 0);
    send_frame(8, msb_bits(32'h15, 8), 0, 0);
    so_valid = 1'b0;
    rx_ready = 1'b1;
    tick();
    check_val("full_pop_ovf", 64'(ovf), 64'd0);
    check_val("full_pop_head", 64'(rx_data), 64'h12);
    for (int k = 'h12; k <= 'h15; k++) begin
      check_val("full_pop_order", 64'(rx_data), 64'(k));
      tick();
    end

    // Reset mid-frame
    send_frame(4, 64'hF, 0, 0);
    do_reset();
    tick();
    check_val("midrst_ferr", 64'(frame_err), 64'd0);
    check_val("midrst_cnt", 64'(err_cnt), 64'd0);
    check_val("midrst_valid", 64'(rx_valid), 64'd0);
    rx_ready = 1'b0;
    send_frame(8, msb_bits(32'hA5, 8), 1, 0);
    check_val("after_rst_data", 64'(rx_data), 64'hA5);
    rx_ready = 1'b1;
    tick();

    // Random frames, random back-pressure, occasional reset
    rnd_ready = 1;
    for (int f = 0; f < 250; f++) begin
      len        = int'($urandom_range(0, 3));
      cfg_length = 2'(len);
      cfg_msb    = 1'($urandom);
      n          = ($urandom_range(0, 2) != 0) ? 8 * (len + 1) : int'($urandom_range(1, 40));
      bits       = {$urandom, $urandom};
      send_frame(n, bits, int'($urandom_range(1, 3)), 0);
      if ($urandom_range(0, 39) == 0) do_reset();
    end
    rx_ready = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
